// File: rtl/lyr2_pkg.sv
// Shared definitions for the lyr2 backward-pass block: Q8.8 constants,
// FSM state encoding, operand slot indices and a saturating add/sub helper.
package lyr2_pkg;

    localparam int WIDTH = 16;
    localparam int FRAC  = 8;

    localparam logic [WIDTH-1:0] ONE  = 16'h0100;
    localparam logic [WIDTH-1:0] QMAX = 16'h7FFF;
    localparam logic [WIDTH-1:0] QMIN = 16'h8000;

    // Slot index of each captured operand in the operand register bank
    localparam int NOPS   = 8;
    localparam int OP_D1  = 0;
    localparam int OP_D2  = 1;
    localparam int OP_W1  = 2;
    localparam int OP_W2  = 3;
    localparam int OP_B   = 4;
    localparam int OP_A   = 5;
    localparam int OP_ERR = 6;
    localparam int OP_LR  = 7;

    typedef enum logic [3:0] {
        IDLE,
        M0,
        M1,
        M2,
        M3,
        M4,
        M5,
        M6,
        DONE
    } state_t;

    // Signed add (sub=0) or subtract (sub=1) with one guard bit, clamped to the Q8.8 range
    function automatic logic [WIDTH-1:0] sat_addsub(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y,
                                                    input logic             sub);
        logic signed [WIDTH:0] sum;
        if (sub) begin
            sum = $signed({x[WIDTH-1], x}) - $signed({y[WIDTH-1], y});
        end else begin
            sum = $signed({x[WIDTH-1], x}) + $signed({y[WIDTH-1], y});
        end
        if (sum[WIDTH] != sum[WIDTH-1]) begin
            return sum[WIDTH] ? QMIN : QMAX;
        end
        return sum[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/qmul_sat.sv
// Combinational signed Q8.8 multiplier: full-width product, arithmetic shift
// by FRAC (rounds toward minus infinity), then clamp to the representable range.
module qmul_sat #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] p
);
    import lyr2_pkg::*;

    localparam logic signed [2*WIDTH-1:0] PMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] PMIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] x_ext;
    logic signed [2*WIDTH-1:0] y_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shifted;

    assign x_ext   = {{WIDTH{x[WIDTH-1]}}, x};
    assign y_ext   = {{WIDTH{y[WIDTH-1]}}, y};
    assign prod    = x_ext * y_ext;
    assign shifted = prod >>> FRAC;

    // Clamp the rescaled product into the signed output word
    always_comb begin
        p = shifted[WIDTH-1:0];
        if (shifted > PMAX) begin
            p = QMAX;
        end else if (shifted < PMIN) begin
            p = QMIN;
        end
    end

endmodule

// File: rtl/lyr2_bwd.sv
// Backward pass of one two-input sigmoid neuron. Seven products are computed
// one per cycle on a single shared multiplier, sequenced by an FSM that sits
// between an input and an output valid/ready handshake.
module lyr2_bwd #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] w1,
    input  logic [WIDTH-1:0] w2,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] err,
    input  logic [WIDTH-1:0] lr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] w1_new,
    output logic [WIDTH-1:0] w2_new,
    output logic [WIDTH-1:0] b_new,
    output logic [WIDTH-1:0] g1,
    output logic [WIDTH-1:0] g2
);
    import lyr2_pkg::*;

    state_t state_reg;
    state_t state_next;
    logic   accept;

    logic [WIDTH-1:0] op_in  [NOPS];
    logic [WIDTH-1:0] op_reg [NOPS];

    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] delta_reg;
    logic [WIDTH-1:0] ld_reg;
    logic [WIDTH-1:0] w1n_reg;
    logic [WIDTH-1:0] w2n_reg;
    logic [WIDTH-1:0] bn_reg;
    logic [WIDTH-1:0] g1_reg;
    logic [WIDTH-1:0] g2_reg;

    logic [WIDTH-1:0] one_minus_a;
    logic [WIDTH-1:0] mul_x;
    logic [WIDTH-1:0] mul_y;
    logic [WIDTH-1:0] mul_p;

    assign op_in[OP_D1]  = d1;
    assign op_in[OP_D2]  = d2;
    assign op_in[OP_W1]  = w1;
    assign op_in[OP_W2]  = w2;
    assign op_in[OP_B]   = b;
    assign op_in[OP_A]   = a;
    assign op_in[OP_ERR] = err;
    assign op_in[OP_LR]  = lr;

    // One capture register per operand, loaded only on the input handshake
    generate
        for (genvar gi = 0; gi < NOPS; gi++) begin : g_cap
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    op_reg[gi] <= '0;
                end else if (accept) begin
                    op_reg[gi] <= op_in[gi];
                end
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs; both handshakes depend only on the state register
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = M0;
                end
            end
            M0:   state_next = M1;
            M1:   state_next = M2;
            M2:   state_next = M3;
            M3:   state_next = M4;
            M4:   state_next = M5;
            M5:   state_next = M6;
            M6:   state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign one_minus_a = sat_addsub(ONE, op_reg[OP_A], 1'b1);

    // Steer the shared multiplier's operands according to the current step
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state_reg)
            M0: begin mul_x = op_reg[OP_A];   mul_y = one_minus_a;    end
            M1: begin mul_x = op_reg[OP_ERR]; mul_y = s_reg;          end
            M2: begin mul_x = op_reg[OP_LR];  mul_y = delta_reg;      end
            M3: begin mul_x = ld_reg;         mul_y = op_reg[OP_D1];  end
            M4: begin mul_x = ld_reg;         mul_y = op_reg[OP_D2];  end
            M5: begin mul_x = delta_reg;      mul_y = op_reg[OP_W1];  end
            M6: begin mul_x = delta_reg;      mul_y = op_reg[OP_W2];  end
            default: begin mul_x = '0;        mul_y = '0;             end
        endcase
    end

    qmul_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_mul (
        .x (mul_x),
        .y (mul_y),
        .p (mul_p)
    );

    // Register each step's result; result registers hold their value otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg     <= '0;
            delta_reg <= '0;
            ld_reg    <= '0;
            w1n_reg   <= '0;
            w2n_reg   <= '0;
            bn_reg    <= '0;
            g1_reg    <= '0;
            g2_reg    <= '0;
        end else begin
            case (state_reg)
                M0: s_reg     <= mul_p;
                M1: delta_reg <= mul_p;
                M2: ld_reg    <= mul_p;
                M3: w1n_reg   <= sat_addsub(op_reg[OP_W1], mul_p, 1'b1);
                M4: begin
                    w2n_reg <= sat_addsub(op_reg[OP_W2], mul_p, 1'b1);
                    bn_reg  <= sat_addsub(op_reg[OP_B], ld_reg, 1'b1);
                end
                M5: g1_reg    <= mul_p;
                M6: g2_reg    <= mul_p;
                default: ;
            endcase
        end
    end

    assign w1_new = w1n_reg;
    assign w2_new = w2n_reg;
    assign b_new  = bn_reg;
    assign g1     = g1_reg;
    assign g2     = g2_reg;

endmodule

// File: tb/tb_lyr2_bwd.sv
// Scoreboard bench for lyr2_bwd: the driver pushes expected results computed
// from the Q8.8 arithmetic rules, a monitor pops them on each output handshake.
module tb_lyr2_bwd;

    typedef struct packed {
        logic [15:0] d1, d2, w1, w2, b, a, err, lr;
    } vec_t;

    typedef struct packed {
        logic [15:0] w1n, w2n, bn, g1, g2;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] d1 = '0, d2 = '0, w1 = '0, w2 = '0, b = '0, a = '0, err = '0, lr = '0;
    logic [15:0] w1_new, w2_new, b_new, g1, g2;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   txn_no = 0;
    res_t exp_q[$];
    int   acc_q[$];
    bit   rand_ready = 1'b0;
    bit   ov_prev = 1'b0;

    lyr2_bwd #(.WIDTH(16), .FRAC(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d1        (d1),
        .d2        (d2),
        .w1        (w1),
        .w2        (w2),
        .b         (b),
        .a         (a),
        .err       (err),
        .lr        (lr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .w1_new    (w1_new),
        .w2_new    (w2_new),
        .b_new     (b_new),
        .g1        (g1),
        .g2        (g2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- reference model (plain integer arithmetic) ----------------
    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int qm(input int x, input int y);
        longint p;
        p = longint'(x) * longint'(y);
        return sat16(p >>> 8);
    endfunction

    function automatic int sv(input logic [15:0] x);
        return int'($signed(x));
    endfunction

    function automatic res_t model(input vec_t v);
        int   s, delta, ld;
        res_t r;
        s     = qm(sv(v.a), sat16(256 - sv(v.a)));
        delta = qm(sv(v.err), s);
        ld    = qm(sv(v.lr), delta);
        r.w1n = 16'(sat16(sv(v.w1) - qm(ld, sv(v.d1))));
        r.w2n = 16'(sat16(sv(v.w2) - qm(ld, sv(v.d2))));
        r.bn  = 16'(sat16(sv(v.b) - ld));
        r.g1  = 16'(qm(delta, sv(v.w1)));
        r.g2  = 16'(qm(delta, sv(v.w2)));
        return r;
    endfunction

    function automatic logic [15:0] rval();
        if ($urandom_range(0, 1) == 1) return 16'($urandom);
        return 16'($urandom_range(0, 1023)) - 16'd512;
    endfunction

    function automatic vec_t rvec();
        vec_t v;
        v.d1 = rval(); v.d2 = rval(); v.w1 = rval(); v.w2 = rval();
        v.b = rval(); v.err = rval(); v.lr = rval();
        v.a = 16'($urandom_range(0, 256));
        return v;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input vec_t v, input res_t e, output int acc);
        int guard;
        guard = 0;
        @(negedge clk);
        {d1, d2, w1, w2, b, a, err, lr} = v;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
            acc = -1;
            return;
        end
        acc = cyc + 1;
        exp_q.push_back(e);
        acc_q.push_back(acc);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                ov_prev = 1'b0;
            end else begin
                if (out_valid && !ov_prev) begin
                    if (acc_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_valid: out_valid=1 with no transaction issued");
                    end else begin
                        chk("latency", 80'(cyc - acc_q.pop_front()), 80'd7);
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h with empty scoreboard",
                                 {w1_new, w2_new, b_new, g1, g2});
                    end else begin
                        res_t e;
                        e = exp_q.pop_front();
                        txn_no++;
                        $display("txn %0d: w1_new=%h w2_new=%h b_new=%h g1=%h g2=%h (exp %h)",
                                 txn_no, w1_new, w2_new, b_new, g1, g2, e);
                        chk("result", {w1_new, w2_new, b_new, g1, g2}, e);
                    end
                end
                ov_prev = out_valid;
            end
        end
    end

    // ---------------- stimulus ----------------
    vec_t nominal = '{d1: 16'h0100, d2: 16'h0200, w1: 16'h0100, w2: 16'hFF00,
                      b: 16'h0000, a: 16'h0080, err: 16'h0100, lr: 16'h0100};
    res_t nominal_exp = '{w1n: 16'h00C0, w2n: 16'hFE80, bn: 16'hFFC0, g1: 16'h0040, g2: 16'hFFC0};
    res_t sat_exp     = '{w1n: 16'h8000, w2n: 16'hFE80, bn: 16'hFFC0, g1: 16'hE000, g2: 16'hFFC0};

    initial begin
        vec_t v;
        res_t e;
        int   acc;
        int   acc_s[3];
        int   guard;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_in_ready", 80'(in_ready), 80'd1);
        chk("reset_out_valid", 80'(out_valid), 80'd0);
        chk("reset_data", {w1_new, w2_new, b_new, g1, g2}, 80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Nominal
        send(nominal, nominal_exp, acc);
        idle();
        drain();

        // Saturation: w1 at the most negative value
        v = nominal;
        v.w1 = 16'h8000;
        send(v, sat_exp, acc);
        idle();
        drain();

        // Zero derivative: a=0 leaves parameters untouched and gradients zero
        for (int i = 0; i < 3; i++) begin
            v = rvec();
            v.a = 16'h0000;
            e = '{w1n: v.w1, w2n: v.w2, bn: v.b, g1: 16'h0, g2: 16'h0};
            send(v, e, acc);
            idle();
        end
        drain();

        // Back-pressure in DONE with inputs toggling
        v = rvec();
        e = model(v);
        @(negedge clk);
        out_ready = 1'b0;
        send(v, e, acc);
        idle();
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            {d1, d2, w1, w2, b, a, err, lr} = {rval(), rval(), rval(), rval(),
                                              rval(), rval(), rval(), rval()};
            in_valid = ($urandom_range(0, 1) == 1);
            #1;
            chk("bp_out_valid", 80'(out_valid), 80'd1);
            chk("bp_in_ready", 80'(in_ready), 80'd0);
            chk("bp_data", {w1_new, w2_new, b_new, g1, g2}, e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("bp_no_capture_valid", 80'(out_valid), 80'd0);
            chk("bp_no_capture_ready", 80'(in_ready), 80'd1);
        end
        drain();

        // Reset during M3 discards the transaction
        send(nominal, nominal_exp, acc);
        idle();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        chk("midrst_out_valid", 80'(out_valid), 80'd0);
        chk("midrst_in_ready", 80'(in_ready), 80'd1);
        chk("midrst_data", {w1_new, w2_new, b_new, g1, g2}, 80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(nominal, nominal_exp, acc);
        idle();
        drain();

        // Streaming: in_valid and out_ready held high across three vectors
        for (int i = 0; i < 3; i++) begin
            v = rvec();
            send(v, model(v), acc_s[i]);
        end
        idle();
        chk("stream_gap_1", 80'(acc_s[1] - acc_s[0]), 80'd9);
        chk("stream_gap_2", 80'(acc_s[2] - acc_s[1]), 80'd9);
        drain();

        // Random traffic with random output back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            v = rvec();
            send(v, model(v), acc);
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
        end
        idle();
        drain();
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
